// File: rtl/ppu_pkg.sv
// Shared constants for the PPU scan-out path: pixel format, sync polarity, default blanking.
// PPU_SCANOUT_DOUBLE_EN selects 2x pixel/line doubling (SCALE=2); undefined gives SCALE=1.
package ppu_pkg;

    localparam int unsigned BPP          = 4;
    localparam int unsigned PIX_PER_WORD = 8;

    localparam logic SYNC_ACT = 1'b0;

    localparam int unsigned H_FRONT_DEF = 8;
    localparam int unsigned H_SYNC_DEF  = 16;
    localparam int unsigned H_BACK_DEF  = 8;
    localparam int unsigned V_FRONT_DEF = 2;
    localparam int unsigned V_SYNC_DEF  = 2;
    localparam int unsigned V_BACK_DEF  = 4;

`ifdef PPU_SCANOUT_DOUBLE_EN
    localparam int unsigned SCALE = 2;
`else
    localparam int unsigned SCALE = 1;
`endif
    localparam int unsigned SCALE_SH = (SCALE == 2) ? 1 : 0;

    // Maps "sync asserted" onto the pin level.
    function automatic logic sync_level(input logic asserted);
        return asserted ? SYNC_ACT : ~SYNC_ACT;
    endfunction

endpackage

// File: rtl/ppu_timing.sv
// Raster counters plus combinational decode of active video, syncs, frame irq and the
// fetch/load/shift strobes that pace VRAM reads (scale from ppu_pkg, PPU_SCANOUT_DOUBLE_EN).
module ppu_timing
    import ppu_pkg::*;
#(
    parameter int unsigned FB_W      = 128,
    parameter int unsigned FB_H      = 128,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 active_c,
    output logic                 hsync_n_c,
    output logic                 vsync_n_c,
    output logic                 frame_irq_c,
    output logic                 fetch_stb_c,
    output logic [CNT_WIDTH-1:0] fetch_row_c,
    output logic [CNT_WIDTH-1:0] fetch_k_c,
    output logic                 load_stb_c,
    output logic                 shift_stb_c
);

    localparam int unsigned CW       = CNT_WIDTH;
    localparam int unsigned CW1      = CNT_WIDTH + 1;
    localparam int unsigned H_ACT    = FB_W * SCALE;
    localparam int unsigned V_ACT    = FB_H * SCALE;
    localparam int unsigned H_TOTAL  = H_ACT + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACT + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_ACT + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACT + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned P        = PIX_PER_WORD * SCALE;
    localparam int unsigned PSH      = $clog2(P);

    logic [CW-1:0]  h_q, h_d, v_q, v_d;
    logic [CW-1:0]  v_nxt;
    logic [CW-1:0]  fetch_line;
    logic [CW1-1:0] hp3, hp1;
    logic           fetch_mid, fetch_wrap, load_mid, load_wrap;

    // Free-running raster position; v advances on h wrap.
    always_comb begin
        h_d   = h_q + CW'(1);
        v_d   = v_q;
        v_nxt = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
        if (h_q == CW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = v_nxt;
        end
    end

    // Reset lands 4 clocks before line 0 so the row-0 word-0 fetch precedes the first pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= CW'(H_TOTAL - 4);
            v_q <= CW'(V_TOTAL - 1);
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Word k shows from h=P*k: address at P*k-3, data load at P*k-1; k=0 wraps into blanking.
    always_comb begin
        hp3         = CW1'(h_q) + CW1'(3);
        hp1         = CW1'(h_q) + CW1'(1);
        fetch_mid   = (hp3[PSH-1:0] == '0) && (hp3 >= CW1'(P)) && (hp3 < CW1'(H_ACT));
        fetch_wrap  = (h_q == CW'(H_TOTAL - 3));
        load_mid    = (hp1[PSH-1:0] == '0) && (hp1 >= CW1'(P)) && (hp1 < CW1'(H_ACT));
        load_wrap   = (h_q == CW'(H_TOTAL - 1));
        fetch_line  = fetch_wrap ? v_nxt : v_q;

        active_c    = (h_q < CW'(H_ACT)) && (v_q < CW'(V_ACT));
        hsync_n_c   = sync_level((h_q >= CW'(HS_START)) && (h_q < CW'(HS_END)));
        vsync_n_c   = sync_level((v_q >= CW'(VS_START)) && (v_q < CW'(VS_END)));
        frame_irq_c = (h_q == '0) && (v_q == CW'(V_ACT));
        fetch_stb_c = fetch_mid || fetch_wrap;
        fetch_k_c   = fetch_mid ? CW'(hp3 >> PSH) : '0;
        fetch_row_c = CW'(fetch_line >> SCALE_SH);
        load_stb_c  = load_mid || load_wrap;
        shift_stb_c = ((h_q & CW'(SCALE - 1)) == CW'(SCALE - 1));
    end

endmodule

// File: rtl/ppu_scanout.sv
// Video scan-out: paces VRAM reads and serialises 32-bit words into 4-bit palette indices
// with aligned de/syncs/frame_irq. PPU_SCANOUT_DOUBLE_EN enables 2x pixel and line doubling.
module ppu_scanout
    import ppu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FB_W       = 128,
    parameter int unsigned FB_H       = 128,
    parameter int unsigned H_FRONT    = H_FRONT_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BACK     = H_BACK_DEF,
    parameter int unsigned V_FRONT    = V_FRONT_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BACK     = V_BACK_DEF,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] addr_ppu,
    input  logic [DATA_WIDTH-1:0] out_ppu,
    output logic [BPP-1:0]        pix,
    output logic                  de,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  frame_irq
);

    localparam int unsigned WORDS_PER_ROW = FB_W / PIX_PER_WORD;

    logic                  active_c, hsync_n_c, vsync_n_c, frame_irq_c;
    logic                  fetch_stb_c, load_stb_c, shift_stb_c;
    logic [CNT_WIDTH-1:0]  fetch_row_c, fetch_k_c;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [BPP-1:0]        pix_q, pix_d;
    logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d, irq_q, irq_d;
    logic [31:0]           word_idx;

    ppu_timing #(
        .FB_W      (FB_W),
        .FB_H      (FB_H),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .active_c    (active_c),
        .hsync_n_c   (hsync_n_c),
        .vsync_n_c   (vsync_n_c),
        .frame_irq_c (frame_irq_c),
        .fetch_stb_c (fetch_stb_c),
        .fetch_row_c (fetch_row_c),
        .fetch_k_c   (fetch_k_c),
        .load_stb_c  (load_stb_c),
        .shift_stb_c (shift_stb_c)
    );

    // Blank-line rows run past the framebuffer; the address simply wraps at ADDR_WIDTH.
    always_comb begin
        word_idx = 32'(fetch_row_c) * 32'(WORDS_PER_ROW) + 32'(fetch_k_c);
        addr_d   = addr_q;
        sh_d     = sh_q;
        if (fetch_stb_c) begin
            addr_d = ADDR_WIDTH'(word_idx << 2);
        end
        if (load_stb_c) begin
            sh_d = out_ppu;
        end else if (shift_stb_c) begin
            sh_d = sh_q >> BPP;
        end
        pix_d = active_c ? sh_q[BPP-1:0] : '0;
        de_d  = active_c;
        hs_d  = hsync_n_c;
        vs_d  = vsync_n_c;
        irq_d = frame_irq_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            sh_q   <= '0;
            pix_q  <= '0;
            de_q   <= 1'b0;
            hs_q   <= ~SYNC_ACT;
            vs_q   <= ~SYNC_ACT;
            irq_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            sh_q   <= sh_d;
            pix_q  <= pix_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            irq_q  <= irq_d;
        end
    end

    assign addr_ppu  = addr_q;
    assign pix       = pix_q;
    assign de        = de_q;
    assign hsync_n   = hs_q;
    assign vsync_n   = vs_q;
    assign frame_irq = irq_q;

endmodule

// File: tb/tb_ppu_scanout.sv
// Scoreboard bench for ppu_scanout: timed expectations are queued, a negedge monitor checks them.
module tb_ppu_scanout;

`ifdef PPU_SCANOUT_DOUBLE_EN
    localparam int unsigned S = 2;
`else
    localparam int unsigned S = 1;
`endif
    localparam int unsigned H     = 128 * S + 32;
    localparam int unsigned VA    = 128 * S;
    localparam int unsigned VT    = VA + 8;
    localparam int unsigned FRAME = H * VT;
    localparam int unsigned P     = 8 * S;

    typedef struct {
        int unsigned c;
        logic [31:0] v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [12:0] addr_ppu;
    logic [31:0] out_ppu;
    logic [3:0]  pix;
    logic        de, hsync_n, vsync_n, frame_irq;

    logic [31:0] mem [0:2047];
    int unsigned cyc;
    int          checks, failures;
    exp_t        pix_q[$];
    exp_t        addr_q[$];
    int unsigned irq_q[$];
    exp_t        me;

    logic        mon_en, geo_en;
    logic        prev_de, prev_hs, prev_vs;
    logic [12:0] prev_addr;
    int unsigned irq_cnt, blank_pix_err;
    int unsigned de_rise_c, de_fall_c, hs_fall_c, vs_fall_c;
    logic        seen_rise, len_done, seen_fall;
    int unsigned hs_st, vs_st;

    ppu_scanout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_ppu  (addr_ppu),
        .out_ppu   (out_ppu),
        .pix       (pix),
        .de        (de),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .frame_irq (frame_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM read port: data valid the cycle after the address is sampled.
    always @(posedge clk) out_ppu <= mem[addr_ppu[12:2]];

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int unsigned line, input int unsigned k);
        return 32'(((line / S) * 16 + k) * 4) & 32'h1FFF;
    endfunction

    function automatic int unsigned fetch_cyc(input int unsigned line, input int unsigned k);
        return 4 + line * H + P * k - 2;
    endfunction

    task automatic push_addr(input int unsigned line, input int unsigned k0, input int unsigned k1);
        for (int k = int'(k0); k <= int'(k1); k++)
            addr_q.push_back('{c: fetch_cyc(line, k), v: exp_addr(line, k)});
    endtask

    task automatic wait_cyc(input int unsigned t);
        int unsigned n;
        n = 0;
        while (cyc != t && n < 200000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != t) chk("wait_cycle_timeout", cyc, t);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"},    32'(addr_ppu),  0);
        chk({tag, "_pix"},     32'(pix),       0);
        chk({tag, "_de"},      32'(de),        0);
        chk({tag, "_hsync_n"}, 32'(hsync_n),   1);
        chk({tag, "_vsync_n"}, 32'(vsync_n),   1);
        chk({tag, "_irq"},     32'(frame_irq), 0);
    endtask

    // Monitor: pops timed expectations, tracks sync geometry for the first frame.
    always @(negedge clk) begin
        if (mon_en) begin
            while (pix_q.size() != 0 && pix_q[0].c <= cyc) begin
                me = pix_q.pop_front();
                chk("pix_de", 32'(de), 1);
                chk("pix_val", 32'(pix), me.v);
            end
            while (addr_q.size() != 0 && addr_q[0].c <= cyc) begin
                me = addr_q.pop_front();
                chk("addr_val", 32'(addr_ppu), me.v);
                chk("addr_update_cycle", 32'(addr_ppu != prev_addr), 1);
            end
            if (frame_irq) begin
                irq_cnt++;
                if (irq_q.size() != 0) chk("irq_cycle", cyc, irq_q.pop_front());
                else                   chk("irq_unexpected", 32'(frame_irq), 0);
            end
            if (!de && pix != 4'd0) blank_pix_err++;
            if (geo_en) begin
                if (de && !prev_de) begin
                    if (!seen_rise) begin
                        seen_rise = 1'b1;
                        de_rise_c = cyc;
                        chk("first_de_cycle", cyc, 5);
                    end else if (!len_done) begin
                        len_done = 1'b1;
                        chk("line_len", cyc - de_rise_c, H);
                    end
                end
                if (!de && prev_de && !seen_fall) begin
                    seen_fall = 1'b1;
                    de_fall_c = cyc;
                end
                if (!hsync_n && prev_hs && hs_st == 0) begin
                    hs_st = 1;
                    hs_fall_c = cyc;
                    chk("hs_after_de_fall", cyc - de_fall_c, 8);
                end else if (hsync_n && !prev_hs && hs_st == 1) begin
                    hs_st = 2;
                    chk("hs_width", cyc - hs_fall_c, 16);
                end
                if (!vsync_n && prev_vs && vs_st == 0) begin
                    vs_st = 1;
                    vs_fall_c = cyc;
                    chk("vs_start", cyc, 4 + (VA + 2) * H + 1);
                end else if (vsync_n && !prev_vs && vs_st == 1) begin
                    vs_st = 2;
                    chk("vs_width", cyc - vs_fall_c, 2 * H);
                end
            end
        end
        prev_de   = de;
        prev_hs   = hsync_n;
        prev_vs   = vsync_n;
        prev_addr = addr_ppu;
    end

    initial begin
        checks = 0; failures = 0;
        mon_en = 1'b0; geo_en = 1'b0;
        prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; prev_addr = '0;
        irq_cnt = 0; blank_pix_err = 0;
        seen_rise = 1'b0; len_done = 1'b0; seen_fall = 1'b0; hs_st = 0; vs_st = 0;
        de_rise_c = 0; de_fall_c = 0; hs_fall_c = 0; vs_fall_c = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[0]  = 32'h7654_3210;
        mem[1]  = 32'hFEDC_BA98;
        mem[16] = 32'h89AB_CDEF;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");

        @(negedge clk);
        for (int x = 0; x < int'(16 * S); x++)
            pix_q.push_back('{c: 5 + x, v: 32'(x / int'(S))});
        for (int x = 0; x < int'(8 * S); x++)
            pix_q.push_back('{c: 5 + H + x, v: (S == 1) ? 32'(15 - x) : 32'(x / int'(S))});
        push_addr(0, 1, 15);
        push_addr(1, 0, 15);
        push_addr(2, 0, 0);
        push_addr(VA - 1, 15, 15);
        push_addr(VA, 0, 0);
        irq_q.push_back(4 + VA * H + 1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        geo_en = 1'b1;

        wait_cyc(4 + FRAME);
        geo_en = 1'b0;
        chk("irq_per_frame", irq_cnt, 1);
        chk("pix_queue_drained", pix_q.size(), 0);
        chk("addr_queue_drained", addr_q.size(), 0);
        chk("irq_queue_drained", irq_q.size(), 0);
        chk("hs_measured", hs_st, 2);
        chk("vs_measured", vs_st, 2);
        chk("line_len_measured", 32'(len_done), 1);

        // Abort mid-frame at active pixel (40,10) of the second frame.
        wait_cyc(4 + FRAME + 10 * H + 40);
        chk("pre_abort_de", 32'(de), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("abort");

        @(negedge clk);
        for (int x = 0; x < int'(8 * S); x++)
            pix_q.push_back('{c: 5 + x, v: 32'(x / int'(S))});
        push_addr(0, 1, 3);
        push_addr(1, 0, 0);
        rst_n = 1'b1;

        wait_cyc(4 + 2 * H + 20);
        chk("restart_pix_drained", pix_q.size(), 0);
        chk("restart_addr_drained", addr_q.size(), 0);
        chk("pix_zero_when_blank", blank_pix_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
